ps2_score_controller: RTL

- Consumes the PS/2 keyboard byte stream and owns both team scores and the game-pause flag.
- Decodes make codes, break codes (F0) and extended codes (E0), and suppresses typematic repeats of a held key.
- Applies saturating score arithmetic and presents registered scores to the 7-segment display path.

---
 rtl/scoreboard_pkg.sv | 57 +++++
 rtl/score_sat_adder.sv | 34 +++
 rtl/ps2_score_controller.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/scoreboard_pkg.sv
// Shared scan codes, FSM/command types and key decoding for ps2_score_controller.
// Optional undo key mapping is compiled in with SCORE_UNDO_EN.
package scoreboard_pkg;

  localparam logic [7:0] KEY_BRK   = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;
  localparam logic [7:0] KEY_PAUSE = 8'h29;
  localparam logic [7:0] KEY_UNDO  = 8'h66;
  localparam logic [7:0] KEY_HA1   = 8'h1C;
  localparam logic [7:0] KEY_HA2   = 8'h1B;
  localparam logic [7:0] KEY_HA3   = 8'h23;
  localparam logic [7:0] KEY_GA1   = 8'h3B;
  localparam logic [7:0] KEY_GA2   = 8'h42;
  localparam logic [7:0] KEY_GA3   = 8'h4B;
  localparam logic [7:0] KEY_HS1   = 8'h22;
  localparam logic [7:0] KEY_HS2   = 8'h21;
  localparam logic [7:0] KEY_HS3   = 8'h2A;
  localparam logic [7:0] KEY_GS1   = 8'h32;
  localparam logic [7:0] KEY_GS2   = 8'h31;
  localparam logic [7:0] KEY_GS3   = 8'h3A;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_e;

  typedef enum logic [2:0] {NONE, HOME_ADJ, GUEST_ADJ, PAUSE_TGL, UNDO} cmd_e;

  typedef struct packed {
    cmd_e              kind;
    logic signed [2:0] delta;
  } cmd_t;

  function automatic cmd_t decode(input logic [7:0] b);
    cmd_t c;
    c.kind  = NONE;
    c.delta = '0;
    case (b)
      KEY_HA1:   begin c.kind = HOME_ADJ;  c.delta =  3'sd1; end
      KEY_HA2:   begin c.kind = HOME_ADJ;  c.delta =  3'sd2; end
      KEY_HA3:   begin c.kind = HOME_ADJ;  c.delta =  3'sd3; end
      KEY_GA1:   begin c.kind = GUEST_ADJ; c.delta =  3'sd1; end
      KEY_GA2:   begin c.kind = GUEST_ADJ; c.delta =  3'sd2; end
      KEY_GA3:   begin c.kind = GUEST_ADJ; c.delta =  3'sd3; end
      KEY_HS1:   begin c.kind = HOME_ADJ;  c.delta = -3'sd1; end
      KEY_HS2:   begin c.kind = HOME_ADJ;  c.delta = -3'sd2; end
      KEY_HS3:   begin c.kind = HOME_ADJ;  c.delta = -3'sd3; end
      KEY_GS1:   begin c.kind = GUEST_ADJ; c.delta = -3'sd1; end
      KEY_GS2:   begin c.kind = GUEST_ADJ; c.delta = -3'sd2; end
      KEY_GS3:   begin c.kind = GUEST_ADJ; c.delta = -3'sd3; end
      KEY_PAUSE: c.kind = PAUSE_TGL;
`ifdef SCORE_UNDO_EN
      KEY_UNDO:  c.kind = UNDO;
`endif
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/score_sat_adder.sv
// Saturating score adjust: score + delta (-3..+3), clamped to [0, max].
module score_sat_adder #(
  parameter int SCORE_W = 8
) (
  input  logic [SCORE_W-1:0] score,
  input  logic signed [2:0]  delta,
  input  logic [SCORE_W-1:0] max,
  output logic [SCORE_W-1:0] result,
  output logic               clamp
);

  logic [1:0]       mag;
  logic [SCORE_W:0] mag_ext;
  logic [SCORE_W:0] sum;

  always_comb begin
    mag     = delta[2] ? (~delta[1:0] + 2'd1) : delta[1:0];
    mag_ext = {{(SCORE_W-1){1'b0}}, mag};
    sum     = delta[2] ? ({1'b0, score} - mag_ext) : ({1'b0, score} + mag_ext);
    result  = sum[SCORE_W-1:0];
    clamp   = 1'b0;
    // On subtract the extra bit is the borrow; on add it is part of the magnitude
    if (delta[2]) begin
      if (sum[SCORE_W]) begin
        result = '0;
        clamp  = 1'b1;
      end
    end else if (sum > {1'b0, max}) begin
      result = max;
      clamp  = 1'b1;
    end
  end

endmodule

// File: rtl/ps2_score_controller.sv
// PS/2 byte-stream decoder owning both team scores and the pause flag.
// Define SCORE_UNDO_EN to build the one-deep Backspace undo record.
module ps2_score_controller
  import scoreboard_pkg::*;
#(
  parameter int SCORE_W   = 8,
  parameter int SCORE_MAX = 199
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         code,
  input  logic               code_valid,
  input  logic               clear,
  output logic [SCORE_W-1:0] home_score,
  output logic [SCORE_W-1:0] guest_score,
  output logic               paused,
  output logic               cmd_ack,
  output logic               sat
);

  localparam logic [SCORE_W-1:0] MAX_L = SCORE_W'(SCORE_MAX);

  state_e            state, state_nxt;
  logic [7:0]        held_code;
  logic              held_vld;
  cmd_t              cmd;
  logic              accept, release_hit;
  logic              do_home, do_guest, do_pause;
  logic              h_wr, g_wr;
  logic signed [2:0] h_delta, g_delta;
  logic [SCORE_W-1:0] h_res, g_res;
  logic              h_clamp, g_clamp;
`ifdef SCORE_UNDO_EN
  logic              rec_vld, rec_team, do_undo;
  logic signed [2:0] rec_delta;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else if (code_valid) begin
      case (state)
        IDLE:    if (code == KEY_BRK) state_nxt = BRK;
                 else if (code == KEY_EXT) state_nxt = EXT;
        BRK:     state_nxt = IDLE;
        EXT:     state_nxt = (code == KEY_BRK) ? EXT_BRK : IDLE;
        EXT_BRK: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    cmd         = decode(code);
    accept      = 1'b0;
    release_hit = 1'b0;
    if (code_valid && !clear) begin
      case (state)
        IDLE: accept = (code != KEY_BRK) && (code != KEY_EXT) &&
                       !(held_vld && (code == held_code));
        BRK:  release_hit = (code == held_code);
        default: ;
      endcase
    end
    do_home  = accept && (cmd.kind == HOME_ADJ);
    do_guest = accept && (cmd.kind == GUEST_ADJ);
    do_pause = accept && (cmd.kind == PAUSE_TGL);
    h_delta  = cmd.delta;
    g_delta  = cmd.delta;
    h_wr     = do_home;
    g_wr     = do_guest;
`ifdef SCORE_UNDO_EN
    // Undo reuses the team's adder with the negated recorded delta; it cannot clamp
    do_undo = accept && (cmd.kind == UNDO) && rec_vld;
    if (do_undo) begin
      if (rec_team) begin
        g_delta = -rec_delta;
        g_wr    = 1'b1;
      end else begin
        h_delta = -rec_delta;
        h_wr    = 1'b1;
      end
    end
`endif
  end

  score_sat_adder #(.SCORE_W(SCORE_W)) u_home_add (
    .score(home_score), .delta(h_delta), .max(MAX_L), .result(h_res), .clamp(h_clamp)
  );

  score_sat_adder #(.SCORE_W(SCORE_W)) u_guest_add (
    .score(guest_score), .delta(g_delta), .max(MAX_L), .result(g_res), .clamp(g_clamp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      home_score  <= '0;
      guest_score <= '0;
      paused      <= 1'b1;
      cmd_ack     <= 1'b0;
      sat         <= 1'b0;
      held_code   <= '0;
      held_vld    <= 1'b0;
    end else if (clear) begin
      home_score  <= '0;
      guest_score <= '0;
      paused      <= 1'b1;
      cmd_ack     <= 1'b0;
      sat         <= 1'b0;
      held_vld    <= 1'b0;
    end else begin
      cmd_ack <= h_wr | g_wr | do_pause;
      sat     <= (do_home & h_clamp) | (do_guest & g_clamp);
      if (accept) begin
        held_code <= code;
        held_vld  <= 1'b1;
      end
      if (release_hit) held_vld <= 1'b0;
      if (h_wr) home_score <= h_res;
      if (g_wr) guest_score <= g_res;
      if (do_pause) paused <= ~paused;
    end
  end

`ifdef SCORE_UNDO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_vld   <= 1'b0;
      rec_team  <= 1'b0;
      rec_delta <= '0;
    end else if (clear || do_undo) begin
      rec_vld <= 1'b0;
    end else if (do_home) begin
      rec_vld   <= 1'b1;
      rec_team  <= 1'b0;
      rec_delta <= 3'(h_res - home_score);
    end else if (do_guest) begin
      rec_vld   <= 1'b1;
      rec_team  <= 1'b1;
      rec_delta <= 3'(g_res - guest_score);
    end
  end
`endif

endmodule
